// File: rtl/booth_mult_radix4_seq.sv
// Sequential radix-4 Booth multiplier: two multiplier bits per clock, signed or unsigned
// operands per operation, valid/ready on both the operand and product sides.
module booth_mult_radix4_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int unsigned E  = WIDTH + 2;
    localparam int unsigned N  = E / 2;
    localparam int unsigned AW = 2 * E;
    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        ms_q;     // multiplicand, pre-shifted by 2i
    logic [E:0]           qs_q;     // multiplier with q[-1], shifted right by 2i
    logic [AW-1:0]        acc_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   p_q;

    logic                 accept;
    logic                 last_digit;
    logic [AW-1:0]        m_ext;
    logic [E:0]           q_ext;
    logic [AW-1:0]        pp;
    logic [AW-1:0]        acc_sum;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    assign last_digit = (cnt_q == LastCnt);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid)  state_d = StCalc;
            StCalc:  if (last_digit) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == StIdle) && !rst;
        out_valid = (state_q == StDone);
        p         = p_q;
    end

    assign accept = in_valid && in_ready;

    // Unsigned operands get zero top bits, so extending straight to the accumulator
    // width keeps both modes exact modulo 2^AW.
    assign m_ext = {{(AW-WIDTH){signed_mode & m[WIDTH-1]}}, m};
    assign q_ext = {{2{signed_mode & q[WIDTH-1]}}, q, 1'b0};

    always_comb begin
        case (qs_q[2:0])
            3'b001, 3'b010: pp = ms_q;
            3'b011:         pp = ms_q << 1;
            3'b100:         pp = -(ms_q << 1);
            3'b101, 3'b110: pp = -ms_q;
            default:        pp = '0;
        endcase
    end

    assign acc_sum = acc_q + pp;

    always_ff @(posedge clk) begin
        if (rst) begin
            ms_q  <= '0;
            qs_q  <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            p_q   <= '0;
        end else if (accept) begin
            ms_q  <= m_ext;
            qs_q  <= q_ext;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == StCalc) begin
            ms_q  <= ms_q << 2;
            qs_q  <= qs_q >> 2;
            acc_q <= acc_sum;
            cnt_q <= cnt_q + CW'(1);
            if (last_digit) p_q <= acc_sum[2*WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_booth_mult_radix4_seq.sv
// Directed and randomised checks of the radix-4 Booth multiplier at WIDTH=8 and WIDTH=16.
module tb_booth_mult_radix4_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv8 = 1'b0, ir8, sm8 = 1'b0, ov8, or8 = 1'b1;
    logic [7:0]  m8 = '0, q8 = '0;
    logic [15:0] p8;

    logic        iv16 = 1'b0, ir16, sm16 = 1'b0, ov16, or16 = 1'b1;
    logic [15:0] m16 = '0, q16 = '0;
    logic [31:0] p16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_mult_radix4_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .m(m8), .q(q8),
        .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .p(p8)
    );

    booth_mult_radix4_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .m(m16), .q(q16),
        .signed_mode(sm16), .out_valid(ov16), .out_ready(or16), .p(p16)
    );

    // Waits for in_ready, presents one operation and returns #1 after the accepting edge.
    task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                           input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (ir8 !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (ir8 !== 1'b1) begin
            bad++;
            $display("FAIL %s ready: in_ready=%b required 1", name, ir8);
        end
        m8 = a; q8 = b; sm8 = sm; iv8 = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                           input logic [15:0] exp, input string name, input bit scramble);
        int lat;
        accept8(a, b, sm, name);
        if (scramble) begin
            m8 = 8'd99; q8 = 8'd99; sm8 = ~sm;
        end else begin
            iv8 = 1'b0;
        end
        lat = 0;
        while (ov8 !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        iv8 = 1'b0;
        total++;
        if (lat != 5) begin
            bad++;
            $display("FAIL %s latency: got %0d cycles required 5", name, lat);
        end
        total++;
        if (p8 !== exp) begin
            bad++;
            $display("FAIL %s product: p=%h required %h", name, p8, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (ir8 !== 1'b0 || ir16 !== 1'b0) begin
            bad++;
            $display("FAIL reset in_ready: got %b/%b required 0/0", ir8, ir16);
        end
        total++;
        if (ov8 !== 1'b0 || p8 !== 16'h0) begin
            bad++;
            $display("FAIL reset outputs: out_valid=%b p=%h required 0 0000", ov8, p8);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (ir8 !== 1'b1 || ir16 !== 1'b1) begin
            bad++;
            $display("FAIL reset release in_ready: got %b/%b required 1/1", ir8, ir16);
        end
    endtask

    task automatic test_signed();
        run_op8(8'd10,  8'd5,   1'b1, 16'd50,   "s10x5",   1'b0);
        run_op8(8'hF4,  8'd3,   1'b1, 16'hFFDC, "sm12x3",  1'b0);
        run_op8(8'd7,   8'hFC,  1'b1, 16'hFFE4, "s7xm4",   1'b0);
        run_op8(8'hF8,  8'hF8,  1'b1, 16'd64,   "sm8xm8",  1'b0);
    endtask

    task automatic test_corners();
        run_op8(8'h80,  8'h80,  1'b1, 16'h4000, "sm128xm128", 1'b0);
        run_op8(8'h80,  8'h7F,  1'b1, 16'hC080, "sm128x127",  1'b0);
        run_op8(8'hFF,  8'hFF,  1'b0, 16'hFE01, "u255x255",   1'b0);
        run_op8(8'd0,   8'd200, 1'b0, 16'h0000, "u0x200",     1'b0);
    endtask

    task automatic test_backpressure();
        int lat;
        bit held_ok;
        or8 = 1'b0;
        accept8(8'd13, 8'd11, 1'b0, "bp");
        iv8 = 1'b0;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++;
        if (ov8 !== 1'b1 || p8 !== 16'd143) begin
            bad++;
            $display("FAIL bp first: out_valid=%b p=%h required 1 008f", ov8, p8);
        end
        held_ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            if (ov8 !== 1'b1 || p8 !== 16'd143 || ir8 !== 1'b0) held_ok = 1'b0;
        end
        total++;
        if (!held_ok) begin
            bad++;
            $display("FAIL bp hold: out_valid=%b p=%h in_ready=%b required 1 008f 0",
                     ov8, p8, ir8);
        end
        or8 = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (ov8 !== 1'b0 || ir8 !== 1'b1 || p8 !== 16'd143) begin
            bad++;
            $display("FAIL bp release: out_valid=%b in_ready=%b p=%h required 0 1 008f",
                     ov8, ir8, p8);
        end
    endtask

    task automatic test_reset_midop();
        bit seen;
        accept8(8'd100, 8'd100, 1'b0, "rstmid");
        iv8 = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (ov8 !== 1'b0 || p8 !== 16'h0 || ir8 !== 1'b0) begin
            bad++;
            $display("FAIL rstmid abort: out_valid=%b p=%h in_ready=%b required 0 0000 0",
                     ov8, p8, ir8);
        end
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (ov8 === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL rstmid no_valid: out_valid seen=1 required 0");
        end
        run_op8(8'd3, 8'd3, 1'b0, 16'd9, "after_rst", 1'b0);
    endtask

    task automatic test_input_change();
        run_op8(8'd6, 8'd7, 1'b0, 16'd42, "busy_change", 1'b1);
    endtask

    task automatic test_wide16();
        for (int i = 0; i < 500; i++) begin
            logic [15:0] a, b;
            logic        sm;
            logic signed [31:0] sa, sb;
            logic [31:0] exp;
            int k, lat;
            a  = 16'($urandom);
            b  = 16'($urandom);
            sm = 1'($urandom);
            sa = {{16{a[15]}}, a};
            sb = {{16{b[15]}}, b};
            exp = sm ? 32'(sa * sb) : ({16'd0, a} * {16'd0, b});
            k = 0;
            @(negedge clk);
            while (ir16 !== 1'b1 && k < 40) begin
                @(negedge clk);
                k++;
            end
            total++;
            if (ir16 !== 1'b1) begin
                bad++;
                $display("FAIL w16 op%0d ready: in_ready=%b required 1", i, ir16);
            end
            m16 = a; q16 = b; sm16 = sm; iv16 = 1'b1;
            @(posedge clk);
            #1;
            iv16 = 1'b0;
            m16 = 16'($urandom); q16 = 16'($urandom); sm16 = 1'($urandom);
            lat = 0;
            while (ov16 !== 1'b1 && lat < 30) begin
                @(posedge clk);
                #1;
                lat++;
                or16 = 1'($urandom);
            end
            total++;
            if (lat != 9) begin
                bad++;
                $display("FAIL w16 op%0d latency: got %0d cycles required 9", i, lat);
            end
            total++;
            if (p16 !== exp) begin
                bad++;
                $display("FAIL w16 op%0d product: a=%h b=%h s=%b p=%h required %h",
                         i, a, b, sm, p16, exp);
            end
            k = 0;
            while (or16 !== 1'b1 && k < 50) begin
                @(posedge clk);
                #1;
                k++;
                or16 = 1'($urandom);
            end
            or16 = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_corners();
        test_backpressure();
        test_reset_midop();
        test_input_change();
        test_wide16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
